// File: rtl/msk_inv_pipe_pkg.sv
// Shared masking helpers: where share j of sharing i sits in a flat share bus.
// Sharing i occupies bits [i*d +: d]; share j of it is bit i*d+j.
package msk_inv_pipe_pkg;

   localparam int SHARE0 = 0;

   function automatic int sharing_bits(input int d, input int count);
      return d * count;
   endfunction

   function automatic int sharing_base(input int d, input int i);
      return i * d;
   endfunction

   function automatic int share_bit(input int d, input int i, input int j);
      return sharing_base(d, i) + j;
   endfunction

endpackage

// File: rtl/msk_inv_stage.sv
// One elastic register stage carrying a valid flag, the share bus and the public invert enables.
// With APPLY_INV set, share 0 of each sharing leaves the stage XORed with its own stored enable.
module msk_inv_stage
   import msk_inv_pipe_pkg::*;
#(
   parameter int d         = 2,
   parameter int count     = 1,
   parameter bit APPLY_INV = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_adv,
   input  logic                 i_valid,
   input  logic [count*d-1:0]   i_data,
   input  logic [count-1:0]     i_inv,
   output logic                 o_valid,
   output logic [count*d-1:0]   o_data,
   output logic [count-1:0]     o_inv
);

   logic                 r_valid;
   logic [count*d-1:0]   r_data;
   logic [count-1:0]     r_inv;

   // Valid flag refills from upstream whenever the stage shifts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
      end else if (i_adv) begin
         r_valid <= i_valid;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Payload is never reset, so no gate ever sees more than one share of a sharing.
   always_ff @(posedge clk) begin
      if (i_adv) begin
         r_data <= i_data;
         r_inv  <= i_inv;
      end else begin
         r_data <= r_data;
         r_inv  <= r_inv;
      end
   end

   assign o_valid = r_valid;
   assign o_inv   = r_inv;

   generate
      if (APPLY_INV) begin : g_inv
         logic [count*d-1:0] w_mask;
         for (genvar gi = 0; gi < count; gi++) begin : g_sharing
            for (genvar gj = 0; gj < d; gj++) begin : g_share
               if (gj == SHARE0) begin : g_s0
                  assign w_mask[share_bit(d, gi, gj)] = r_inv[gi];
               end else begin : g_sn
                  assign w_mask[share_bit(d, gi, gj)] = 1'b0;
               end
            end
         end
         assign o_data = r_data ^ w_mask;
      end else begin : g_pass
         assign o_data = r_data;
      end
   endgenerate

endmodule

// File: rtl/msk_inv_pipe.sv
// Masked conditional NOT: LAT elastic stages, public inversion of share 0 in the last stage.
// Affine and share-wise isolated, so the gadget is secure at any order d.
(* fv_prop = "affine", fv_strat = "isolate", fv_order = d *)
module msk_inv_pipe
   import msk_inv_pipe_pkg::*;
#(
   parameter int d     = 2,
   parameter int count = 1,
   parameter int LAT   = 1
) (
   (* fv_type = "clock" *)
   input  logic                 clk,
   (* fv_type = "control" *)
   input  logic                 rst,
   (* fv_type = "sharing", fv_latency = 0, fv_count = count *)
   input  logic [count*d-1:0]   in,
   (* fv_type = "control" *)
   input  logic [count-1:0]     inv_en,
   (* fv_type = "control" *)
   input  logic                 in_valid,
   (* fv_type = "control" *)
   output logic                 in_ready,
   (* fv_type = "sharing", fv_latency = LAT, fv_count = count *)
   output logic [count*d-1:0]   out,
   (* fv_type = "control" *)
   output logic                 out_valid,
   (* fv_type = "control" *)
   input  logic                 out_ready
);

   localparam int W = sharing_bits(d, count);

   logic [LAT:0]              w_valid;
   logic [LAT:0]              w_adv;
   logic [LAT:0][W-1:0]       w_data;
   logic [LAT:0][count-1:0]   w_inv;
   logic [count-1:0]          w_unused_inv;

   assign w_valid[0] = in_valid;
   assign w_data[0]  = in;
   assign w_inv[0]   = inv_en;

   // Stage k shifts when it or any later stage holds a bubble, or the output is being taken.
   always_comb begin
      w_adv      = '0;
      w_adv[LAT] = out_ready;
      for (int k = LAT - 1; k >= 0; k--) begin
         w_adv[k] = ~w_valid[k+1] | w_adv[k+1];
      end
   end

   for (genvar gk = 0; gk < LAT; gk++) begin : g_stage
      msk_inv_stage #(
         .d         (d),
         .count     (count),
         .APPLY_INV (gk == LAT - 1)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_adv   (w_adv[gk]),
         .i_valid (w_valid[gk]),
         .i_data  (w_data[gk]),
         .i_inv   (w_inv[gk]),
         .o_valid (w_valid[gk+1]),
         .o_data  (w_data[gk+1]),
         .o_inv   (w_inv[gk+1])
      );
   end

   assign in_ready     = w_adv[0];
   assign out          = w_data[LAT];
   assign out_valid    = w_valid[LAT];
   assign w_unused_inv = w_inv[LAT];

endmodule

// File: tb/tb_msk_inv_pipe.sv
// Bench for msk_inv_pipe: directed handshake scenarios plus random traffic against a queue model.
module tb_msk_inv_pipe;

   localparam int D   = 2;
   localparam int CNT = 2;
   localparam int L   = 2;
   localparam int W   = D * CNT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [W-1:0]   in_s;
   logic [CNT-1:0] inv_s;
   logic           in_valid_s;
   logic           in_ready_s;
   logic [W-1:0]   out_s;
   logic           out_valid_s;
   logic           out_ready_s;

   logic [2:0]     in1_s;
   logic [2:0]     inv1_s;
   logic           in_valid1_s;
   logic           in_ready1_s;
   logic [2:0]     out1_s;
   logic           out_valid1_s;
   logic           out_ready1_s;

   msk_inv_pipe #(.d(D), .count(CNT), .LAT(L)) dut (
      .clk(clk), .rst(rst), .in(in_s), .inv_en(inv_s), .in_valid(in_valid_s),
      .in_ready(in_ready_s), .out(out_s), .out_valid(out_valid_s), .out_ready(out_ready_s)
   );

   msk_inv_pipe #(.d(1), .count(3), .LAT(1)) dut1 (
      .clk(clk), .rst(rst), .in(in1_s), .inv_en(inv1_s), .in_valid(in_valid1_s),
      .in_ready(in_ready1_s), .out(out1_s), .out_valid(out_valid1_s), .out_ready(out_ready1_s)
   );

   typedef struct {
      logic [W-1:0]   din;
      logic [CNT-1:0] inv;
      int             acc;
   } xfer_t;

   xfer_t        q[$];
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   int           n_acc = 0;
   bit           exact_lat = 1'b0;
   bit           hold_pending = 1'b0;
   logic [W-1:0] held_out;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Spec rule: share 0 of sharing i flips when inv_en[i]=1, every other share passes through.
   function automatic logic [W-1:0] ref_out(input logic [W-1:0] din, input logic [CNT-1:0] inv);
      logic [W-1:0] r;
      r = din;
      for (int i = 0; i < CNT; i++) begin
         if (inv[i]) r[i*D] = ~r[i*D];
      end
      return r;
   endfunction

   function automatic logic [CNT-1:0] share_xor(input logic [W-1:0] v);
      logic [CNT-1:0] x;
      x = '0;
      for (int i = 0; i < CNT; i++) begin
         for (int j = 0; j < D; j++) x[i] = x[i] ^ v[i*D+j];
      end
      return x;
   endfunction

   // Evaluate the handshakes that will occur at the next rising edge, then advance one cycle.
   task automatic step();
      xfer_t t;
      #1;
      check_eq("in_ready", in_ready_s, ((q.size() < L) || out_ready_s));
      if (out_valid_s) check_eq("no_spurious", (q.size() > 0), 1'b1);
      if (hold_pending) begin
         check_eq("hold_valid", out_valid_s, 1'b1);
         check_eq("hold_out", out_s, held_out);
      end
      if (out_valid_s && out_ready_s && (q.size() > 0)) begin
         t = q.pop_front();
         check_eq("out_data", out_s, ref_out(t.din, t.inv));
         check_eq("share_xor", share_xor(out_s), share_xor(t.din) ^ t.inv);
         if (exact_lat) check_eq("latency", cyc - t.acc, L);
         else check_eq("latency_min", ((cyc - t.acc) >= L), 1'b1);
      end
      if (rst) begin
         q.delete();
      end else if (in_valid_s && in_ready_s) begin
         q.push_back('{in_s, inv_s, cyc});
         n_acc++;
      end
      hold_pending = out_valid_s && !out_ready_s && !rst;
      held_out     = out_s;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      int ov_cnt;
      int ov_first;
      int ov_last;
      int acc0;
      logic [2:0] exp1;

      rst = 1'b1; in_s = '0; inv_s = '0; in_valid_s = 1'b0; out_ready_s = 1'b0;
      in1_s = '0; inv1_s = '0; in_valid1_s = 1'b0; out_ready1_s = 1'b0;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      check_eq("rst_out_valid", out_valid_s, 1'b0);
      check_eq("rst_in_ready", in_ready_s, 1'b1);
      check_eq("rst_out_valid1", out_valid1_s, 1'b0);

      // Single transfer: out appears exactly L cycles after acceptance.
      exact_lat = 1'b1;
      out_ready_s = 1'b1;
      in_s = 4'b1011; inv_s = 2'b01; in_valid_s = 1'b1;
      step();
      in_valid_s = 1'b0; in_s = 4'($urandom); inv_s = 2'($urandom);
      check_eq("single_early", out_valid_s, 1'b0);
      step();
      check_eq("single_valid", out_valid_s, 1'b1);
      check_eq("single_out", out_s, 4'b1010);
      step();
      check_eq("single_gone", out_valid_s, 1'b0);

      // Eight back-to-back transfers with no back-pressure.
      ov_cnt = 0; ov_first = -1; ov_last = -1;
      for (int k = 0; k < 8 + L + 2; k++) begin
         in_valid_s = (k < 8);
         in_s = 4'($urandom); inv_s = 2'($urandom);
         if (k < 8) check_eq("stream_ready", in_ready_s, 1'b1);
         step();
         if (out_valid_s) begin
            ov_cnt++;
            if (ov_first < 0) ov_first = cyc;
            ov_last = cyc;
         end
      end
      check_eq("stream_count", ov_cnt, 8);
      check_eq("stream_run", ov_last - ov_first + 1, 8);
      check_eq("stream_drained", q.size(), 0);

      // Back-pressure: only L transfers fit, outputs held until released.
      exact_lat = 1'b0;
      out_ready_s = 1'b0;
      acc0 = n_acc;
      for (int k = 0; k < 5; k++) begin
         in_valid_s = 1'b1; in_s = 4'($urandom); inv_s = 2'($urandom);
         step();
      end
      check_eq("bp_accepted", n_acc - acc0, L);
      check_eq("bp_in_ready", in_ready_s, 1'b0);
      check_eq("bp_out_valid", out_valid_s, 1'b1);
      in_valid_s = 1'b0; out_ready_s = 1'b1;
      for (int k = 0; k < 10 && q.size() > 0; k++) step();
      check_eq("bp_drained", q.size(), 0);
      step();

      // Reset with two transfers in flight, plus one offered during reset.
      out_ready_s = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid_s = 1'b1; in_s = 4'($urandom); inv_s = 2'($urandom);
         step();
      end
      check_eq("flight_full", out_valid_s, 1'b1);
      rst = 1'b1; in_valid_s = 1'b1; in_s = 4'($urandom);
      step();
      rst = 1'b0; in_valid_s = 1'b0;
      check_eq("midrst_out_valid", out_valid_s, 1'b0);
      check_eq("midrst_in_ready", in_ready_s, 1'b1);
      out_ready_s = 1'b1;
      ov_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (out_valid_s) ov_cnt++;
      end
      check_eq("midrst_no_stale", ov_cnt, 0);

      // d=1, count=3, LAT=1 instance.
      in1_s = 3'b101; inv1_s = 3'b110; in_valid1_s = 1'b1; out_ready1_s = 1'b1;
      @(posedge clk); @(negedge clk); cyc++;
      check_eq("d1_valid", out_valid1_s, 1'b1);
      check_eq("d1_out", out1_s, 3'b011);
      in_valid1_s = 1'b0;
      @(posedge clk); @(negedge clk); cyc++;
      check_eq("d1_gone", out_valid1_s, 1'b0);
      for (int k = 0; k < 16; k++) begin
         in1_s = 3'($urandom); inv1_s = 3'($urandom); in_valid1_s = 1'b1;
         exp1 = in1_s ^ inv1_s;
         check_eq("d1_ready", in_ready1_s, 1'b1);
         @(posedge clk); @(negedge clk); cyc++;
         check_eq("d1_rand_valid", out_valid1_s, 1'b1);
         check_eq("d1_rand_out", out1_s, exp1);
      end
      in_valid1_s = 1'b0;

      // Random traffic with random back-pressure and rare resets.
      for (int k = 0; k < 400; k++) begin
         in_valid_s  = ($urandom_range(0, 3) != 0);
         out_ready_s = ($urandom_range(0, 3) != 0);
         in_s  = 4'($urandom);
         inv_s = 2'($urandom);
         rst   = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b1;
      for (int k = 0; k < 10 && q.size() > 0; k++) step();
      check_eq("final_drained", q.size(), 0);
      check_eq("final_idle", out_valid_s, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/msk_inv_pipe.md
MSK_INV_PIPE -- requirements
Module: msk_inv_pipe

Interface
REQ-001 SHALL have parameter d, default 2: number of shares per sharing (>=1).
REQ-002 SHALL have parameter count, default 1: number of independent sharings (>=1).
REQ-003 SHALL have parameter LAT, default 1: pipeline depth in register stages (>=1).
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in, input, count*d: input sharings; sharing i occupies bits [i*d +: d], share j at bit i*d+j.
REQ-007 SHALL have port inv_en, input, count: public per-sharing invert enable, sampled with in.
REQ-008 SHALL have port in_valid, input, 1: upstream offers in/inv_en.
REQ-009 SHALL have port in_ready, output, 1: block accepts a transfer this cycle.
REQ-010 SHALL have port out, output, count*d: output sharings, same bit layout as in.
REQ-011 SHALL have port out_valid, output, 1: out holds a valid result.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts out this cycle.

Function
REQ-013 SHALL, per transfer, output sharing i share 0 = ~in share 0 when inv_en[i]=1, else in share 0 unchanged; shares 1..d-1 SHALL pass unchanged (affine, share-wise isolated).
REQ-014 SHALL count a transfer on input when in_valid & in_ready, and on output when out_valid & out_ready, both at a rising clk edge.
REQ-015 SHALL implement LAT stages, each holding a valid bit, count*d data bits and count inv_en bits; the inversion SHALL be applied in the final stage only, with no cross-share logic anywhere.
REQ-016 SHALL, with no back-pressure, present an accepted transfer on out exactly LAT cycles after acceptance (out_valid high in cycle t+LAT).
REQ-017 SHALL advance stage k when stage k is empty or stage k+1 (or the output, for the last stage) advances in the same cycle; in_ready SHALL equal the advance condition of stage 0 (combinational from out_ready through the stage valid bits).
REQ-018 SHALL hold out, out_valid and all stage contents stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, when full (all LAT stages valid) and out_ready=1, accept a new input in the same cycle (full throughput of one transfer per cycle).
REQ-020 SHALL never drop, duplicate or reorder transfers; at most LAT transfers are in flight.
REQ-021 SHALL ignore in and inv_en when in_valid=0 or in_ready=0.
REQ-022 SHALL make d=1 legal (only share 0, inverted under inv_en).

Reset
REQ-023 SHALL, on rst=1 at a clk edge, clear all stage valid bits; out_valid SHALL be 0 in the following cycle, in_ready SHALL be 1.
REQ-024 SHALL discard in-flight transfers on reset mid-operation; a transfer offered in the reset cycle SHALL NOT be accepted.
REQ-025 SHALL NOT reset share data registers (no share-combining reset logic); out content is don't-care while out_valid=0.

Structure
REQ-026 SHALL place share-indexing helpers (sharing/share bit offset constants) in the shared masking package used by the MSK library.
REQ-027 SHALL use one sub-module, msk_inv_stage, implementing one elastic register stage (valid, data, inv_en), instantiated LAT times.
REQ-028 SHALL carry fullverif annotations: sharing ports with fv_latency=LAT, fv_count=count; affine property, isolate strategy, order d.

Verification
REQ-029 Bench (d=2,count=2,LAT=2): in=4'b1011, inv_en=2'b01, in_valid=1 one cycle, out_ready=1 -> out_valid high exactly 2 cycles later, out=4'b1010.
REQ-030 Bench: stream 8 transfers back-to-back with out_ready=1 -> in_ready stays 1, 8 consecutive out_valid cycles, values in order.
REQ-031 Bench: out_ready=0 for 5 cycles while streaming -> exactly 2 transfers held, in_ready=0 after pipeline full, out stable; releasing yields all values in order without loss.
REQ-032 Bench: assert rst with 2 transfers in flight -> next cycle out_valid=0, in_ready=1, no stale transfer ever appears.
REQ-033 Bench (d=1,count=3,LAT=1): in=3'b101, inv_en=3'b110 -> out=3'b011 one cycle later.
REQ-034 Bench: random stimulus against a reference model -> XOR of output shares equals (XOR of input shares) ^ inv_en per sharing, on every output transfer.
